act_relu_quant: RTL
===================

ACT_RELU_QUANT -- requirements
Module: act_relu_quant

Interface
REQ-001 Parameter ACC_WIDTH, default 32, signed accumulator width from the systolic array.
REQ-002 Parameter DATA_WIDTH, default 8, quantized activation width delivered to pooling.
REQ-003 Parameter ADDRESS_WIDTH, default 10, feature-map address width.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_start_i  input  1  one-cycle pulse starting a feature map; honoured only in IDLE.
REQ-007 cfg_len_m1_i  input  ADDRESS_WIDTH  feature-map output count minus 1; latched on accepted start.
REQ-008 cfg_shift_i  input  5  requantization right-shift amount; latched on accepted start.
REQ-009 cfg_bias_i  input  ACC_WIDTH  signed bias; latched on accepted start.
REQ-010 acc_valid_i  input  1  accumulator sample valid.
REQ-011 acc_data_i  input  ACC_WIDTH  signed accumulator sample.
REQ-012 act_valid_o  output  1  activation result valid, to pooling act_valid_i.
REQ-013 act_last_o  output  1  final result of the feature map, coincident with act_valid_o.
REQ-014 act_result_o  output  DATA_WIDTH  unsigned quantized activation.
REQ-015 act_result_address_o  output  ADDRESS_WIDTH  feature-map address of act_result_o.
REQ-016 busy_o  output  1  high in RUN or DRAIN.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE->RUN on cfg_start_i; RUN->DRAIN on acceptance of sample number cfg_len_m1+1; DRAIN->IDLE when pipeline holds no valid stage.
REQ-018 acc_valid_i accepted only in RUN; ignored in IDLE and DRAIN; cfg_start_i ignored outside IDLE.
REQ-019 No backpressure: every accepted sample produces exactly one output 3 cycles later (accept at edge N -> act_valid_o high after edge N+3).
REQ-020 Stage 1: sum = sign-extended acc_data + sign-extended bias in ACC_WIDTH+1 bits, no overflow possible.
REQ-021 Stage 2: ReLU (sum<0 -> 0); then if shift=0 value unchanged, else value = (value + 2^(shift-1)) >> shift (round-half-up).
REQ-022 Stage 3: saturate to 2^DATA_WIDTH-1 if value exceeds it; drive act_result_o.
REQ-023 Input address counter cleared to 0 on accepted start, incremented per accepted sample; address travels with its sample through the pipeline.
REQ-024 act_last_o high only on the output whose address equals latched cfg_len_m1; never asserted without act_valid_o.
REQ-025 cfg_len_m1 = 0: single sample; RUN lasts until first accepted sample, output carries act_last_o=1, address 0.
REQ-026 cfg_len_m1 = 2^ADDRESS_WIDTH-1: addresses 0..max without wrap; counter not incremented past max.
REQ-027 Gaps (acc_valid_i low) in RUN allowed; pipeline bubbles propagate as act_valid_o low.
REQ-028 cfg_start_i coincident with acc_valid_i in IDLE: start accepted, sample ignored.
REQ-029 busy_o falls the cycle after the last output valid; new start accepted that cycle onward.

Reset
REQ-030 rst high asynchronously forces IDLE, clears counters, pipeline valids, and latched config.
REQ-031 Reset values: act_valid_o 0, act_last_o 0, act_result_o 0, act_result_address_o 0, busy_o 0.
REQ-032 Reset mid-RUN or mid-DRAIN discards in-flight samples; no output valid until a new start after release.

Verification
REQ-033 len_m1=3, bias=0, shift=0, inputs 5,-7,300,255 back-to-back -> results 5,0,255,255 at addresses 0..3, last only at address 3, latency 3.
REQ-034 shift=2, bias=-10, inputs 16,12,0 (len_m1=2) -> sums 6,2,-10 -> results 2,1,0 (rounded 1.5->2, 0.5->1).
REQ-035 len_m1=0, single input 42, bias 0 -> one output 42, address 0, last=1; busy_o back to 0 the following cycle.
REQ-036 len_m1=3 with acc_valid_i pattern 1,0,0,1,1,0,1 -> 4 outputs with same gaps, addresses 0..3, extra acc_valid_i in DRAIN/IDLE produce nothing.
REQ-037 Assert rst after 2 of 8 samples -> all outputs 0 immediately; post-reset samples without start produce no act_valid_o.
REQ-038 cfg_start_i pulsed during RUN -> ignored; latched len/shift/bias unchanged, addresses continue.

Source files
------------

// File: rtl/act_relu_quant.sv
// act_relu_quant: bias add, ReLU, round-half-up requantization and unsigned
// saturation for one feature map of systolic-array accumulator samples.
// A small IDLE/RUN/DRAIN controller frames the map; the datapath is a fixed
// four-register pipeline (capture, sum, relu/round, saturate) with no stalls,
// so a sample accepted at edge N appears on the outputs after edge N+3.
module act_relu_quant #(
  parameter int ACC_WIDTH     = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_start_i,
  input  logic [ADDRESS_WIDTH-1:0]        cfg_len_m1_i,
  input  logic [4:0]                      cfg_shift_i,
  input  logic signed [ACC_WIDTH-1:0]     cfg_bias_i,
  input  logic                            acc_valid_i,
  input  logic signed [ACC_WIDTH-1:0]     acc_data_i,
  output logic                            act_valid_o,
  output logic                            act_last_o,
  output logic [DATA_WIDTH-1:0]           act_result_o,
  output logic [ADDRESS_WIDTH-1:0]        act_result_address_o,
  output logic                            busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched feature-map configuration
  logic [ADDRESS_WIDTH-1:0]    r_len_m1;
  logic [4:0]                  r_shift;
  logic signed [ACC_WIDTH-1:0] r_bias;

  // Address of the next sample to be accepted
  logic [ADDRESS_WIDTH-1:0]    r_addr;

  logic w_start;
  logic w_accept;
  logic w_addr_at_end;
  logic w_pipe_busy;

  // Pipeline control (reset) and data (not reset)
  logic r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
  logic r_last_p0, r_last_p1, r_last_p2, r_last_p3;

  logic signed [ACC_WIDTH-1:0] r_acc_p0;
  logic [ADDRESS_WIDTH-1:0]    r_addr_p0, r_addr_p1, r_addr_p2, r_addr_p3;
  logic signed [ACC_WIDTH:0]   r_sum_p1;
  logic [ACC_WIDTH:0]          r_val_p2;
  logic [DATA_WIDTH-1:0]       r_res_p3;

  logic signed [ACC_WIDTH:0]   w_sum_p0;
  logic [ACC_WIDTH:0]          w_val_p1;
  logic [DATA_WIDTH-1:0]       w_res_p2;

  // ReLU followed by an optional round-half-up right shift. The clamped
  // value is below 2^ACC_WIDTH, so adding the half-LSB cannot overflow
  // ACC_WIDTH+1 unsigned bits.
  function automatic logic [ACC_WIDTH:0] relu_round(
    input logic signed [ACC_WIDTH:0] s,
    input logic [4:0]                sh
  );
    logic [ACC_WIDTH:0] v;
    logic [ACC_WIDTH:0] half;
    if (s[ACC_WIDTH]) begin
      v = '0;
    end else begin
      v = {1'b0, s[ACC_WIDTH-1:0]};
    end
    if (sh == 5'd0) begin
      relu_round = v;
    end else begin
      half       = (ACC_WIDTH+1)'(1) << (sh - 5'd1);
      relu_round = (v + half) >> sh;
    end
  endfunction

  // Clamp a non-negative value to the unsigned DATA_WIDTH range
  function automatic logic [DATA_WIDTH-1:0] saturate(
    input logic [ACC_WIDTH:0] v
  );
    if (|v[ACC_WIDTH:DATA_WIDTH]) begin
      saturate = '1;
    end else begin
      saturate = v[DATA_WIDTH-1:0];
    end
  endfunction

  assign w_start       = (r_state == S_IDLE) && cfg_start_i;
  assign w_accept      = (r_state == S_RUN) && acc_valid_i;
  assign w_addr_at_end = (r_addr == r_len_m1);
  // The output stage is excluded so IDLE is reached on the edge that retires
  // the final result, dropping busy the cycle after that result is shown.
  assign w_pipe_busy   = r_vld_p0 | r_vld_p1 | r_vld_p2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start opens a map, the final sample closes it, drain
  // waits for the in-flight samples to retire
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_start_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept && w_addr_at_end) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_pipe_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Configuration latch and input address counter; the counter holds at the
  // final address rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_m1 <= '0;
      r_shift  <= '0;
      r_bias   <= '0;
      r_addr   <= '0;
    end else if (w_start) begin
      r_len_m1 <= cfg_len_m1_i;
      r_shift  <= cfg_shift_i;
      r_bias   <= cfg_bias_i;
      r_addr   <= '0;
    end else if (w_accept && !w_addr_at_end) begin
      r_addr   <= r_addr + ADDRESS_WIDTH'(1);
    end
  end

  // Valid/last tracking through the pipeline and the reset-visible outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
      r_last_p3 <= 1'b0;
      r_addr_p3 <= '0;
      r_res_p3  <= '0;
    end else begin
      r_vld_p0  <= w_accept;
      r_vld_p1  <= r_vld_p0;
      r_vld_p2  <= r_vld_p1;
      r_vld_p3  <= r_vld_p2;
      r_last_p3 <= r_vld_p2 & r_last_p2;
      r_addr_p3 <= r_addr_p2;
      r_res_p3  <= w_res_p2;
    end
  end

  // ---- stage p0 -> p1: bias add in ACC_WIDTH+1 bits (cannot overflow)
  assign w_sum_p0 = {r_acc_p0[ACC_WIDTH-1], r_acc_p0} + {r_bias[ACC_WIDTH-1], r_bias};

  // ---- stage p1 -> p2: ReLU and round-half-up shift
  assign w_val_p1 = relu_round(r_sum_p1, r_shift);

  // ---- stage p2 -> p3: saturate to unsigned DATA_WIDTH
  assign w_res_p2 = saturate(r_val_p2);

  // Datapath registers; qualified only by the valid bits that travel beside them
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc_p0  <= acc_data_i;
      r_addr_p0 <= r_addr;
      r_last_p0 <= w_addr_at_end;
    end
    r_sum_p1  <= w_sum_p0;
    r_addr_p1 <= r_addr_p0;
    r_last_p1 <= r_last_p0;
    r_val_p2  <= w_val_p1;
    r_addr_p2 <= r_addr_p1;
    r_last_p2 <= r_last_p1;
  end

  assign act_valid_o          = r_vld_p3;
  assign act_last_o           = r_last_p3;
  assign act_result_o         = r_res_p3;
  assign act_result_address_o = r_addr_p3;
  assign busy_o               = (r_state != S_IDLE);

endmodule
